// File: rtl/alu_datapath_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_arb_pkg
// Description : FSM state codes, strobe-vector bit positions and clog2 helper
//               shared by the ALU datapath arbiter and its picker.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] GRANT  = 3'd1;
  localparam logic [STATE_W-1:0] LOAD_A = 3'd2;
  localparam logic [STATE_W-1:0] LOAD_B = 3'd3;
  localparam logic [STATE_W-1:0] EXEC   = 3'd4;
  localparam logic [STATE_W-1:0] WB     = 3'd5;
  localparam logic [STATE_W-1:0] DONE   = 3'd6;

  // Bit positions inside the registered datapath strobe vector
  localparam int STB_REG1_OUT   = 0;
  localparam int STB_ALU_A      = 1;
  localparam int STB_REG2_OUT   = 2;
  localparam int STB_ALU_B      = 3;
  localparam int STB_ALU_IN_EN  = 4;
  localparam int STB_ALU_OUT_EN = 5;
  localparam int STB_REG_DEST   = 6;
  localparam int STB_W          = 7;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_datapath_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational requester picker. Round-robin from rr_ptr by
//               default; lowest-index fixed priority when
//               ALU_ARB_FIXED_PRIO_EN is defined (rr_ptr then ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_vld
);

  logic [PTR_W-1:0] w_idx;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest set index is the last one written
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    w_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = PTR_W'(i);
      if (req[w_idx]) begin
        win_oh         = '0;
        win_oh[w_idx]  = 1'b1;
        win_idx        = w_idx;
        win_vld        = 1'b1;
      end
    end
  end
`else
  int w_sum;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    w_idx   = '0;
    w_sum   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = int'(rr_ptr) + k;
      if (w_sum >= N_REQ) begin
        w_sum = w_sum - N_REQ;
      end
      w_idx = PTR_W'(w_sum);
      if (!win_vld && req[w_idx]) begin
        win_oh[w_idx] = 1'b1;
        win_idx       = w_idx;
        win_vld       = 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_datapath_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_datapath_arbiter
// Description : Shares one register-file/ALU datapath among N_REQ requesters:
//               arbitrates, latches the winner's fields and sequences the
//               load/exec/writeback strobes. ALU_ARB_FIXED_PRIO_EN selects
//               fixed lowest-index priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_datapath_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int OP_W  = 4,
  parameter int RA_W  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*OP_W-1:0]  req_op,
  input  logic [N_REQ*RA_W-1:0]  req_src1,
  input  logic [N_REQ*RA_W-1:0]  req_src2,
  input  logic [N_REQ*RA_W-1:0]  req_dst,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [RA_W-1:0]        rd_addr_a,
  output logic [RA_W-1:0]        rd_addr_b,
  output logic [RA_W-1:0]        wr_addr,
  output logic [OP_W-1:0]        alu_op,
  output logic                   reg1_out,
  output logic                   alu_a,
  output logic                   reg2_out,
  output logic                   alu_b,
  output logic                   alu_in_en,
  output logic                   alu_out_en,
  output logic                   reg_dest
);

  localparam int c_PTR_W = clog2(N_REQ);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;

  logic [N_REQ-1:0]   w_win_oh;
  logic [c_PTR_W-1:0] w_win_idx;
  logic               w_win_vld;
  logic [c_PTR_W-1:0] w_rr_ptr;
  logic               w_any_req;

  logic [N_REQ-1:0]   w_gnt_nxt;
  logic [N_REQ-1:0]   w_done_nxt;
  logic [STB_W-1:0]   w_stb_nxt;
  logic               w_busy_nxt;

  logic [N_REQ-1:0]   r_win_oh;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_done;
  logic [STB_W-1:0]   r_stb;
  logic               r_busy;
  logic [RA_W-1:0]    r_rd_addr_a;
  logic [RA_W-1:0]    r_rd_addr_b;
  logic [RA_W-1:0]    r_wr_addr;
  logic [OP_W-1:0]    r_alu_op;

  assign w_any_req = |req;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (c_PTR_W)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (w_rr_ptr),
    .win_oh  (w_win_oh),
    .win_idx (w_win_idx),
    .win_vld (w_win_vld)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [c_PTR_W-1:0] r_rr_ptr;
  logic [c_PTR_W-1:0] r_win_idx;

  // Pointer moves just past the finishing winner so it gets lowest priority next
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr  <= '0;
      r_win_idx <= '0;
    end else begin
      if (r_state == GRANT && w_win_vld) begin
        r_win_idx <= w_win_idx;
      end
      if (r_state == DONE) begin
        r_rr_ptr <= (r_win_idx == c_PTR_W'(N_REQ - 1)) ? '0
                                                        : r_win_idx + c_PTR_W'(1);
      end
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A request withdrawn before GRANT evaluates leaves no winner: fall back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_any_req ? GRANT : IDLE;
      GRANT:   w_state_nxt = w_win_vld ? LOAD_A : IDLE;
      LOAD_A:  w_state_nxt = LOAD_B;
      LOAD_B:  w_state_nxt = EXEC;
      EXEC:    w_state_nxt = WB;
      WB:      w_state_nxt = DONE;
      DONE:    w_state_nxt = w_any_req ? GRANT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt  = '0;
    w_done_nxt = '0;
    w_stb_nxt  = '0;
    w_busy_nxt = (r_state != IDLE);
    case (r_state)
      GRANT: begin
        w_gnt_nxt = w_win_oh;
      end
      LOAD_A: begin
        w_stb_nxt[STB_REG1_OUT] = 1'b1;
        w_stb_nxt[STB_ALU_A]    = 1'b1;
      end
      LOAD_B: begin
        w_stb_nxt[STB_REG2_OUT] = 1'b1;
        w_stb_nxt[STB_ALU_B]    = 1'b1;
      end
      EXEC: begin
        w_stb_nxt[STB_ALU_IN_EN] = 1'b1;
      end
      WB: begin
        w_stb_nxt[STB_ALU_OUT_EN] = 1'b1;
        w_stb_nxt[STB_REG_DEST]   = 1'b1;
      end
      DONE: begin
        w_done_nxt = r_win_oh;
      end
      default: begin
        w_gnt_nxt = '0;
      end
    endcase
  end

  // Output registers and the per-op field latches (captured only in GRANT)
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_gnt       <= '0;
      r_done      <= '0;
      r_stb       <= '0;
      r_busy      <= 1'b0;
      r_win_oh    <= '0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_wr_addr   <= '0;
      r_alu_op    <= '0;
    end else begin
      r_gnt  <= w_gnt_nxt;
      r_done <= w_done_nxt;
      r_stb  <= w_stb_nxt;
      r_busy <= w_busy_nxt;
      if (r_state == GRANT && w_win_vld) begin
        r_win_oh    <= w_win_oh;
        r_rd_addr_a <= req_src1[w_win_idx*RA_W +: RA_W];
        r_rd_addr_b <= req_src2[w_win_idx*RA_W +: RA_W];
        r_wr_addr   <= req_dst[w_win_idx*RA_W +: RA_W];
        r_alu_op    <= req_op[w_win_idx*OP_W +: OP_W];
      end
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign busy       = r_busy;
  assign rd_addr_a  = r_rd_addr_a;
  assign rd_addr_b  = r_rd_addr_b;
  assign wr_addr    = r_wr_addr;
  assign alu_op     = r_alu_op;
  assign reg1_out   = r_stb[STB_REG1_OUT];
  assign alu_a      = r_stb[STB_ALU_A];
  assign reg2_out   = r_stb[STB_REG2_OUT];
  assign alu_b      = r_stb[STB_ALU_B];
  assign alu_in_en  = r_stb[STB_ALU_IN_EN];
  assign alu_out_en = r_stb[STB_ALU_OUT_EN];
  assign reg_dest   = r_stb[STB_REG_DEST];

endmodule
`default_nettype wire
